pam4_frame_sync: RTL and testbench
==================================

# pam4_frame_sync

Downstream consumer of the CDR's recovered symbol stream. On each `sym_en` strobe (the CDR `Sample_en`) it takes the sliced PAM4 symbol `S`, Gray-demaps it to a dibit and searches for a 16-bit sync word. It acquires frame lock with a HUNT/VERIFY/LOCKED state machine and then packs the payload symbols into bytes with a one-cycle valid strobe. It also flags illegal symbol codes and sync misses, giving the link layer a lock indication and byte-aligned data.

## Interface
- `SYNC_WORD`, default 16'hE4B1: 8-symbol sync pattern, first symbol in bits [15:14].
- `FRAME_SYMS`, default 64: payload symbols per frame. Must be a multiple of 4 and at least 4.
- `LOCK_HITS`, default 3: consecutive sync matches needed to declare lock, counting the HUNT match. Must be at least 2.
- `MISS_LIMIT`, default 4: consecutive sync misses in LOCKED that drop lock. Must be at least 1.

Ports (clock and reset first):
- `clk` input 1: system clock. Single clock domain.
- `rst` input 1: reset, synchronous, active-high.
- `sym_en` input 1: symbol strobe, one cycle wide, arbitrary spacing.
- `sym` input 4, signed: sliced symbol. Legal values are -3, -1, +1, +3.
- `byte_out` output 8: assembled payload byte.
- `byte_valid` output 1: one-cycle strobe qualifying `byte_out`.
- `frame_start` output 1: one-cycle pulse at each confirmed sync while locked.
- `locked` output 1: frame lock status (level).
- `sync_miss` output 1: one-cycle pulse on a missing sync at an expected position, in VERIFY or LOCKED.
- `sym_err` output 1: one-cycle pulse when `sym` is illegal.

## Operation
- Everything advances only on a cycle with `sym_en`=1. Cycles with `sym_en`=0 hold all state, and all pulse outputs are 0 on those cycles.
- Demap (Gray):
  - -3 maps to 00, -1 to 01, +1 to 11, +3 to 10.
  - Any other value maps to 00 and pulses `sym_err`.
- Shift register: `sr` (16 bits) updates as `sr <= {sr[13:0], d}`.
- Fill counter: after reset, no sync compare happens until 8 symbols have been shifted in.
- Match test: `match` = (`sr` after the update == `SYNC_WORD`), evaluated on the current symbol.
- Frame period: P = 8 + FRAME_SYMS.
- Position counter `pos`:
  - Set to 0 on the symbol that produced an accepted match.
  - Otherwise increments on each symbol.
  - When `pos` reaches P, a sync check occurs and `pos` returns to 0.
  - Payload symbols are those with `pos` in 1..FRAME_SYMS after the increment.
- State machine:
  - **HUNT**: compare on every symbol. On `match`: go to VERIFY, set `hits`=1, set `pos`=0.
  - **VERIFY**: at each check, a `match` increments `hits`. If `hits` reaches LOCK_HITS, go to LOCKED and pulse `frame_start`. A miss pulses `sync_miss` and returns to HUNT; no hunt compare is made on that same symbol. No bytes are emitted in VERIFY.
  - **LOCKED**: at each check, a `match` clears `misses` and pulses `frame_start`. A miss pulses `sync_miss` and increments `misses`. If `misses` reaches MISS_LIMIT, go to HUNT and clear `locked`. Otherwise stay in LOCKED and flywheel, keeping the same `pos` timing.
- Byte packing (LOCKED only):
  - Payload dibits are packed first-symbol-in-MSB: byte = {d1, d2, d3, d4}.
  - `byte_valid` pulses when `pos` is a multiple of 4 within 4..FRAME_SYMS.
  - This yields FRAME_SYMS/4 bytes per frame.
  - Sync symbols are never packed.
  - Bytes start with the frame that follows the lock transition.
- `locked` = (state == LOCKED).
- Illegal symbols are still shifted in (as 00) and still counted in `pos`.

## Timing
- All outputs are registered.
- Pulses and status changes appear in the cycle after the `clk` edge at which `sym_en` was sampled high.
- Latency: sym to `byte_valid` is 1 clock after the 4th symbol of the byte.
- Reset values: `byte_out`=0, `byte_valid`=0, `frame_start`=0, `locked`=0, `sync_miss`=0, `sym_err`=0. Internally, state=HUNT and `sr`, `pos`, `hits`, `misses` and the fill counter are 0.
- Reset mid-frame: takes effect at the next edge regardless of `sym_en`. A partial byte is discarded and never emitted. Lock must be fully re-acquired.
- `sym_en` held high continuously (one symbol per clock) is supported with no lost symbols.
- Counter widths:
  - `pos` is sized for 0..P.
  - `hits` and `misses` saturate at their limits and never wrap.

## Test plan
- Reset, then 20 `sym_en` pulses of +1: `sr` matches no sync word, so `locked`=0 throughout. `sym_err`, `byte_valid` and `frame_start` never pulse.
- Defaults, continuous `sym_en`, 5 frames of SYNC_WORD + payload bytes 0x00..0x0F: sync_miss never pulses. `locked` rises 1 clock after the last symbol of the 3rd sync, together with `frame_start`. Frames 4 and 5 each emit 16 bytes, 0x00..0x0F in order. `frame_start` pulses at each sync.
- Illegal symbol 4'sd0 injected at payload position 1 while locked: `sym_err` is high for 1 cycle, and that frame's first byte has bits [7:6]=00.
- While locked, corrupt 1 sync word: `sync_miss` pulses once, `locked` stays 1 and the bytes continue unchanged. Then corrupt 4 consecutive syncs: `locked` drops 1 clock after the 4th bad sync's last symbol, and no further bytes are emitted.
- In VERIFY (after 1 good sync), place a bad second sync: `sync_miss` pulses and the block returns to HUNT. Then 3 good syncs lock again.
- `sym_en` with irregular gaps (1..5 idle cycles) and `rst` asserted at payload position 10: the output sequence is identical modulo timing. After reset the outputs are 0 within 1 clock, the partial byte is not emitted, and relock needs 3 fresh syncs.

Source files
------------

// File: rtl/pam4_frame_sync.sv
// PAM4 frame synchroniser: Gray-demaps sliced symbols, hunts for the sync word,
// confirms lock over several frames and packs payload dibits into bytes.
module pam4_frame_sync #(
    parameter logic [15:0] SYNC_WORD  = 16'hE4B1,
    parameter int          FRAME_SYMS = 64,
    parameter int          LOCK_HITS  = 3,
    parameter int          MISS_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sym_en,
    input  logic signed [3:0] sym,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    output logic              frame_start,
    output logic              locked,
    output logic              sync_miss,
    output logic              sym_err
);

    localparam int P  = 8 + FRAME_SYMS;
    localparam int PW = $clog2(P + 1);
    localparam int HW = $clog2(LOCK_HITS + 1);
    localparam int MW = $clog2(MISS_LIMIT + 1);

    localparam logic [PW-1:0] P_L      = PW'(P);
    localparam logic [PW-1:0] FRAME_L  = PW'(FRAME_SYMS);
    localparam logic [HW-1:0] HITS_L   = HW'(LOCK_HITS);
    localparam logic [HW-1:0] HITS_M1  = HW'(LOCK_HITS - 1);
    localparam logic [MW-1:0] MISS_M1  = MW'(MISS_LIMIT - 1);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t          state_q, state_d;
    // Only the seven most recent dibits are kept; the incoming one completes the window.
    logic [13:0]     sr_q, sr_d;
    logic [3:0]      fill_q, fill_d;
    logic [PW-1:0]   pos_q, pos_d;
    logic [HW-1:0]   hits_q, hits_d;
    logic [MW-1:0]   misses_q, misses_d;
    logic [5:0]      acc_q, acc_d;
    logic [7:0]      byte_q, byte_d;
    logic            byte_valid_q, byte_valid_d;
    logic            frame_start_q, frame_start_d;
    logic            sync_miss_q, sync_miss_d;
    logic            sym_err_q, sym_err_d;

    logic [1:0]      dibit;
    logic            illegal;
    logic            match;
    logic [PW-1:0]   pos_inc;
    logic            at_check;

    always_comb begin
        dibit   = 2'b00;
        illegal = 1'b0;
        case (sym)
            4'sb1101: dibit = 2'b00;
            4'sb1111: dibit = 2'b01;
            4'sb0001: dibit = 2'b11;
            4'sb0011: dibit = 2'b10;
            default:  illegal = 1'b1;
        endcase
    end

    assign match    = ({sr_q, dibit} == SYNC_WORD);
    assign pos_inc  = pos_q + 1'b1;
    assign at_check = (pos_inc == P_L);

    always_comb begin
        state_d       = state_q;
        sr_d          = sr_q;
        fill_d        = fill_q;
        pos_d         = pos_q;
        hits_d        = hits_q;
        misses_d      = misses_q;
        acc_d         = acc_q;
        byte_d        = byte_q;
        byte_valid_d  = 1'b0;
        frame_start_d = 1'b0;
        sync_miss_d   = 1'b0;
        sym_err_d     = 1'b0;

        if (sym_en) begin
            sym_err_d = illegal;
            sr_d      = {sr_q[11:0], dibit};
            if (fill_q != 4'd8) begin
                fill_d = fill_q + 4'd1;
            end

            unique case (state_q)
                HUNT: begin
                    if (match && fill_q >= 4'd7) begin
                        state_d = VERIFY;
                        hits_d  = HW'(1);
                        pos_d   = '0;
                    end
                end
                VERIFY: begin
                    pos_d = at_check ? '0 : pos_inc;
                    if (at_check) begin
                        if (match) begin
                            if (hits_q >= HITS_M1) begin
                                state_d       = LOCKED;
                                hits_d        = HITS_L;
                                misses_d      = '0;
                                frame_start_d = 1'b1;
                            end else begin
                                hits_d = hits_q + 1'b1;
                            end
                        end else begin
                            state_d     = HUNT;
                            hits_d      = '0;
                            sync_miss_d = 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    pos_d = at_check ? '0 : pos_inc;
                    if (!at_check && pos_inc <= FRAME_L) begin
                        acc_d = {acc_q[3:0], dibit};
                        if (pos_inc[1:0] == 2'b00) begin
                            byte_d       = {acc_q, dibit};
                            byte_valid_d = 1'b1;
                        end
                    end
                    if (at_check) begin
                        if (match) begin
                            misses_d      = '0;
                            frame_start_d = 1'b1;
                        end else begin
                            sync_miss_d = 1'b1;
                            if (misses_q >= MISS_M1) begin
                                state_d  = HUNT;
                                misses_d = '0;
                                hits_d   = '0;
                            end else begin
                                misses_d = misses_q + 1'b1;
                            end
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= HUNT;
            sr_q          <= '0;
            fill_q        <= '0;
            pos_q         <= '0;
            hits_q        <= '0;
            misses_q      <= '0;
            acc_q         <= '0;
            byte_q        <= '0;
            byte_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            sync_miss_q   <= 1'b0;
            sym_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            sr_q          <= sr_d;
            fill_q        <= fill_d;
            pos_q         <= pos_d;
            hits_q        <= hits_d;
            misses_q      <= misses_d;
            acc_q         <= acc_d;
            byte_q        <= byte_d;
            byte_valid_q  <= byte_valid_d;
            frame_start_q <= frame_start_d;
            sync_miss_q   <= sync_miss_d;
            sym_err_q     <= sym_err_d;
        end
    end

    assign byte_out    = byte_q;
    assign byte_valid  = byte_valid_q;
    assign frame_start = frame_start_q;
    assign sync_miss   = sync_miss_q;
    assign sym_err     = sym_err_q;
    assign locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_pam4_frame_sync.sv
// Directed bench for pam4_frame_sync: lock acquisition, byte packing, flywheel,
// verify failure, illegal symbols, irregular strobes and mid-frame reset.
module tb_pam4_frame_sync;

    localparam logic [15:0] SYNC = 16'hE4B1;
    localparam logic [15:0] BAD  = 16'hE4B2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sym_en = 1'b0;
    logic signed [3:0] sym = 4'sd0;
    logic [7:0]        byte_out;
    logic              byte_valid, frame_start, locked, sync_miss, sym_err;

    pam4_frame_sync dut (
        .clk(clk), .rst(rst), .sym_en(sym_en), .sym(sym),
        .byte_out(byte_out), .byte_valid(byte_valid), .frame_start(frame_start),
        .locked(locked), .sync_miss(sync_miss), .sym_err(sym_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int gap_mode = 0;
    int fs_cnt, miss_cnt, err_cnt;
    logic lk_pre;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    function automatic logic signed [3:0] sym_of(input logic [1:0] d);
        case (d)
            2'b00:   return -4'sd3;
            2'b01:   return -4'sd1;
            2'b11:   return 4'sd1;
            default: return 4'sd3;
        endcase
    endfunction

    task automatic clear_obs();
        rx_q.delete();
        exp_q.delete();
        fs_cnt = 0; miss_cnt = 0; err_cnt = 0;
    endtask

    task automatic idle(input int n);
        sym_en = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({byte_valid, frame_start, sync_miss, sym_err} !== 4'b0000) begin
                n_fail++;
                $display("FAIL idle_pulses got=%b want=0000",
                         {byte_valid, frame_start, sync_miss, sym_err});
            end
        end
    endtask

    task automatic put_sym(input logic signed [3:0] v);
        if (gap_mode != 0) idle($urandom_range(1, 5));
        sym_en = 1'b1;
        sym    = v;
        @(posedge clk); #1;
        if (byte_valid) rx_q.push_back(byte_out);
        if (frame_start) fs_cnt++;
        if (sync_miss) miss_cnt++;
        if (sym_err) err_cnt++;
    endtask

    task automatic send_sync(input logic [15:0] w);
        for (int i = 7; i >= 1; i--) put_sym(sym_of(w[2*i +: 2]));
        lk_pre = locked;
        put_sym(sym_of(w[1:0]));
    endtask

    task automatic send_payload(input logic [7:0] base, input int first, input int last);
        logic [7:0] b;
        for (int k = first; k <= last; k++) begin
            b = base + 8'(k);
            for (int i = 3; i >= 0; i--) put_sym(sym_of(b[2*i +: 2]));
        end
    endtask

    task automatic send_frame(input logic [15:0] w, input logic [7:0] base, input bit expect_bytes);
        send_sync(w);
        send_payload(base, 0, 15);
        if (expect_bytes)
            for (int k = 0; k < 16; k++) exp_q.push_back(base + 8'(k));
        $display("frame sync=%h base=%h locked=%0b bytes_rx=%0d", w, base, locked, rx_q.size());
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sym_en = 1'b0;
        clear_obs();
    endtask

    task automatic test_reset();
        rst = 1'b1; sym_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({byte_out, byte_valid, frame_start, locked, sync_miss, sym_err} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h want=0",
                     {byte_out, byte_valid, frame_start, locked, sync_miss, sym_err});
        end
        rst = 1'b0;
        clear_obs();
        for (int i = 0; i < 20; i++) begin
            put_sym(4'sd1);
            n_checks++;
            if (locked !== 1'b0) begin
                n_fail++;
                $display("FAIL no_sync_locked sym=%0d got=%b want=0", i, locked);
            end
        end
        n_checks++;
        if (err_cnt != 0 || rx_q.size() != 0 || fs_cnt != 0) begin
            n_fail++;
            $display("FAIL no_sync_pulses err=%0d bytes=%0d fs=%0d want=0 0 0",
                     err_cnt, rx_q.size(), fs_cnt);
        end
        $display("test_reset done");
    endtask

    task automatic test_lock();
        do_reset();
        for (int f = 1; f <= 5; f++) begin
            send_sync(SYNC);
            n_checks++;
            if (lk_pre !== (f > 3) || locked !== (f >= 3)) begin
                n_fail++;
                $display("FAIL lock_seq frame=%0d pre=%b post=%b want=%b %b",
                         f, lk_pre, locked, (f > 3), (f >= 3));
            end
            n_checks++;
            if (frame_start !== (f >= 3)) begin
                n_fail++;
                $display("FAIL lock_frame_start frame=%0d got=%b want=%b", f, frame_start, (f >= 3));
            end
            send_payload(8'h00, 0, 15);
            if (f >= 3) for (int k = 0; k < 16; k++) exp_q.push_back(8'(k));
            $display("frame sync=%h base=00 locked=%0b bytes_rx=%0d", SYNC, locked, rx_q.size());
        end
        n_checks++;
        if (rx_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL lock_byte_count got=%0d want=%0d", rx_q.size(), exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                n_checks++;
                if (rx_q[k] !== exp_q[k]) begin
                    n_fail++;
                    $display("FAIL lock_byte idx=%0d got=%h want=%h", k, rx_q[k], exp_q[k]);
                end
            end
        end
        n_checks++;
        if (miss_cnt != 0 || fs_cnt != 3 || err_cnt != 0) begin
            n_fail++;
            $display("FAIL lock_counts miss=%0d fs=%0d err=%0d want=0 3 0", miss_cnt, fs_cnt, err_cnt);
        end
    endtask

    task automatic test_sym_err();
        clear_obs();
        send_sync(SYNC);
        put_sym(4'sd0);
        n_checks++;
        if (sym_err !== 1'b1) begin
            n_fail++;
            $display("FAIL sym_err_pulse got=%b want=1", sym_err);
        end
        put_sym(sym_of(2'b11));
        n_checks++;
        if (sym_err !== 1'b0) begin
            n_fail++;
            $display("FAIL sym_err_width got=%b want=0", sym_err);
        end
        put_sym(sym_of(2'b00));
        put_sym(sym_of(2'b00));
        send_payload(8'hF0, 1, 15);
        $display("frame sync=%h base=f0 (bad first symbol) bytes_rx=%0d", SYNC, rx_q.size());
        n_checks++;
        if (rx_q.size() != 16) begin
            n_fail++;
            $display("FAIL sym_err_bytes got=%0d want=16", rx_q.size());
        end else begin
            n_checks++;
            if (rx_q[0] !== 8'h30 || rx_q[1] !== 8'hF1) begin
                n_fail++;
                $display("FAIL sym_err_byte0 got=%h %h want=30 f1", rx_q[0], rx_q[1]);
            end
        end
        n_checks++;
        if (err_cnt != 1) begin
            n_fail++;
            $display("FAIL sym_err_count got=%0d want=1", err_cnt);
        end
    endtask

    task automatic test_flywheel();
        clear_obs();
        send_sync(BAD);
        n_checks++;
        if (sync_miss !== 1'b1 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL fly_single miss=%b locked=%b want=1 1", sync_miss, locked);
        end
        send_payload(8'h40, 0, 15);
        for (int k = 0; k < 16; k++) exp_q.push_back(8'h40 + 8'(k));
        send_frame(SYNC, 8'h60, 1'b1);
        for (int b = 0; b < 4; b++) begin
            send_sync(BAD);
            n_checks++;
            if (sync_miss !== 1'b1 || locked !== (b < 3)) begin
                n_fail++;
                $display("FAIL fly_run bad=%0d miss=%b locked=%b want=1 %b", b, sync_miss, locked, (b < 3));
            end
            send_payload(8'h70 + 8'(16 * b), 0, 15);
            if (b < 3) for (int k = 0; k < 16; k++) exp_q.push_back(8'h70 + 8'(16 * b + k));
        end
        n_checks++;
        if (rx_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL fly_byte_count got=%0d want=%0d", rx_q.size(), exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                n_checks++;
                if (rx_q[k] !== exp_q[k]) begin
                    n_fail++;
                    $display("FAIL fly_byte idx=%0d got=%h want=%h", k, rx_q[k], exp_q[k]);
                end
            end
        end
        n_checks++;
        if (miss_cnt != 5 || fs_cnt != 1) begin
            n_fail++;
            $display("FAIL fly_counts miss=%0d fs=%0d want=5 1", miss_cnt, fs_cnt);
        end
    endtask

    task automatic test_verify_miss();
        do_reset();
        send_frame(SYNC, 8'h00, 1'b0);
        send_sync(BAD);
        n_checks++;
        if (sync_miss !== 1'b1 || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL verify_miss miss=%b locked=%b want=1 0", sync_miss, locked);
        end
        send_payload(8'h00, 0, 15);
        for (int f = 1; f <= 3; f++) begin
            send_sync(SYNC);
            n_checks++;
            if (locked !== (f == 3)) begin
                n_fail++;
                $display("FAIL verify_relock frame=%0d got=%b want=%b", f, locked, (f == 3));
            end
            send_payload(8'h00, 0, 15);
        end
        n_checks++;
        if (miss_cnt != 1 || rx_q.size() != 16) begin
            n_fail++;
            $display("FAIL verify_counts miss=%0d bytes=%0d want=1 16", miss_cnt, rx_q.size());
        end
    endtask

    task automatic test_gaps_reset();
        gap_mode = 1;
        do_reset();
        send_frame(SYNC, 8'h00, 1'b0);
        send_frame(SYNC, 8'h00, 1'b0);
        send_frame(SYNC, 8'h10, 1'b1);
        n_checks++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL gap_lock got=%b want=1", locked);
        end
        send_sync(SYNC);
        send_payload(8'h20, 0, 1);
        put_sym(sym_of(2'b00));
        put_sym(sym_of(2'b10));
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h21);
        n_checks++;
        if (rx_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL gap_byte_count got=%0d want=%0d", rx_q.size(), exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                n_checks++;
                if (rx_q[k] !== exp_q[k]) begin
                    n_fail++;
                    $display("FAIL gap_byte idx=%0d got=%h want=%h", k, rx_q[k], exp_q[k]);
                end
            end
        end
        rst = 1'b1; sym_en = 1'b1; sym = sym_of(2'b00);
        @(posedge clk); #1;
        rst = 1'b0; sym_en = 1'b0;
        n_checks++;
        if ({byte_out, byte_valid, frame_start, locked, sync_miss, sym_err} !== 13'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs got=%h want=0",
                     {byte_out, byte_valid, frame_start, locked, sync_miss, sym_err});
        end
        clear_obs();
        put_sym(sym_of(2'b10));
        send_payload(8'h20, 3, 15);
        n_checks++;
        if (rx_q.size() != 0) begin
            n_fail++;
            $display("FAIL midreset_partial got=%0d bytes want=0", rx_q.size());
        end
        for (int f = 1; f <= 3; f++) begin
            send_sync(SYNC);
            n_checks++;
            if (locked !== (f == 3)) begin
                n_fail++;
                $display("FAIL midreset_relock frame=%0d got=%b want=%b", f, locked, (f == 3));
            end
            send_payload(8'h30, 0, 15);
        end
        n_checks++;
        if (rx_q.size() != 16 || rx_q[0] !== 8'h30 || rx_q[15] !== 8'h3F) begin
            n_fail++;
            $display("FAIL midreset_bytes count=%0d want=16 first/last 30 3f", rx_q.size());
        end
        gap_mode = 0;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_sym_err();
        test_flywheel();
        test_verify_miss();
        test_gaps_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
